// File: rtl/grant_arbiter_8.sv
// Eight-way round-robin arbiter with registered grant index/valid decoded to a one-hot bus.
// Optional hold watchdog enabled by defining ARB_TIMEOUT_EN (HOLD_MAX sets the limit).

module decode_3_8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);
    always_comb begin
        y = '0;
        if (en) y[sel] = 1'b1;
    end
endmodule

module grant_arbiter_8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_onehot,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [2:0] winner;
    logic       release_norm;
    logic       expire;

    // Scan offsets from farthest to nearest so the nearest set request after ptr wins;
    // offset 8 wraps to ptr itself, giving it the lowest priority.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] w;
        logic [2:0] c;
        w = p;
        for (int i = 8; i >= 1; i--) begin
            c = p + 3'(i);
            if (r[c]) w = c;
        end
        return w;
    endfunction

    assign winner       = rr_pick(req, ptr_q);
    assign release_norm = done || !req[gnt_idx_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            IDLE, GAP: begin
                if (|req) begin
                    state_d     = BUSY;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = winner;
                    ptr_d       = winner;
                end else begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (release_norm || expire) begin
                    state_d     = GAP;
                    gnt_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd7;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX);

    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;

    // Counter sits at zero outside BUSY, so it is already clear on every BUSY entry.
    assign expire = (state_q == BUSY) && (hold_cnt_q == CW'(HOLD_MAX - 1));

    always_comb begin
        hold_cnt_d = (state_q == BUSY) ? hold_cnt_q + 1'b1 : '0;
        if (state_q == BUSY && (release_norm || expire)) hold_cnt_d = '0;
        timeout_d  = (state_q == BUSY) && expire && !release_norm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_hold;
    assign unused_hold = (HOLD_MAX < 2);
    assign expire      = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

    decode_3_8 u_dec (
        .en  (gnt_valid_q),
        .sel (gnt_idx_q),
        .y   (gnt_onehot)
    );
endmodule

// File: tb/tb_grant_arbiter_8.sv
// Directed bench for grant_arbiter_8: per-cycle check against a behavioural model plus literal pins.
`timescale 1ns/1ps

module tb_grant_arbiter_8;
    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grant_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    // Model: who holds the resource, how long it has held it, and who was served last.
    logic       m_valid;
    logic [2:0] m_idx;
    logic [2:0] m_ptr;
    logic       m_to;
    int         m_held;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_idx   <= 3'd0;
            m_ptr   <= 3'd7;
            m_to    <= 1'b0;
            m_held  <= 0;
        end else begin
            m_to <= 1'b0;
            if (m_valid) begin
                if (done || !req[m_idx]) begin
                    m_valid <= 1'b0;
                    m_held  <= 0;
                end else if (TO_ON && m_held >= HOLD) begin
                    m_valid <= 1'b0;
                    m_held  <= 0;
                    m_to    <= 1'b1;
                end else begin
                    m_held <= m_held + 1;
                end
            end else if (req != 8'h00) begin
                int pick;
                pick = -1;
                for (int k = 1; k <= 8; k++) begin
                    int c;
                    c = (int'(m_ptr) + k) % 8;
                    if (pick < 0 && req[c]) pick = c;
                end
                m_valid <= 1'b1;
                m_idx   <= 3'(pick);
                m_ptr   <= 3'(pick);
                m_held  <= 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        logic [12:0] act, exp;
        act = {gnt_valid, gnt_idx, gnt_onehot, timeout};
        exp = {m_valid, m_idx, (m_valid ? (8'h01 << m_idx) : 8'h00), m_to};
        chk("model {valid,idx,onehot,timeout}", int'(act), int'(exp));
    endtask

    task automatic cyc(input logic [7:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        #12;
        chk("reset valid",  int'(gnt_valid),  0);
        chk("reset idx",    int'(gnt_idx),    0);
        chk("reset onehot", int'(gnt_onehot), 8'h00);
        chk("reset timeout", int'(timeout),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // First grant after reset goes to requester 0
        cyc(8'hFF, 1'b0);
        chk("first idx",    int'(gnt_idx),    0);
        chk("first onehot", int'(gnt_onehot), 8'h01);

        // Full rotation with a single empty cycle between holders
        for (int i = 1; i <= 8; i++) begin
            cyc(8'hFF, 1'b1);
            chk("rr gap valid", int'(gnt_valid), 0);
            cyc(8'hFF, 1'b0);
            chk("rr idx", int'(gnt_idx), i % 8);
            chk("rr onehot", int'(gnt_onehot), int'(8'h01 << (i % 8)));
        end

        // Holder 0 releases; only 5 requests, so 5 wins
        cyc(8'h20, 1'b1);
        cyc(8'h20, 1'b0);
        chk("grant5 idx", int'(gnt_idx), 5);
        // 5 stays requesting after done: 2 beats it
        cyc(8'h24, 1'b1);
        chk("gap after 5", int'(gnt_valid), 0);
        cyc(8'h24, 1'b0);
        chk("rr skips 5", int'(gnt_idx), 2);

        // Holder drops req and asserts done together: one gap, then 5
        cyc(8'h20, 1'b1);
        chk("drop+done gap", int'(gnt_valid), 0);
        cyc(8'h20, 1'b0);
        chk("after drop idx", int'(gnt_idx), 5);
        chk("after drop valid", int'(gnt_valid), 1);

        // Idle done pulses are ignored
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b1);
        chk("idle done valid", int'(gnt_valid), 0);
        cyc(8'h00, 1'b0);
        cyc(8'h08, 1'b0);
        chk("grant3 idx", int'(gnt_idx), 3);

        // Holder never signals done
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < HOLD - 1; i++) begin
            cyc(8'h18, 1'b0);
            chk("hold valid", int'(gnt_valid), 1);
        end
        cyc(8'h18, 1'b0);
        chk("forced gap valid", int'(gnt_valid), 0);
        chk("timeout pulse", int'(timeout), 1);
        cyc(8'h18, 1'b0);
        chk("after timeout idx", int'(gnt_idx), 4);
        chk("timeout cleared", int'(timeout), 0);
`else
        for (int i = 0; i < 110; i++) begin
            cyc(8'h18, 1'b0);
            chk("long hold", int'({gnt_valid, gnt_idx, timeout}), int'({1'b1, 3'd3, 1'b0}));
        end
`endif
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b0);

        // Asynchronous reset in the middle of a grant to 3
        cyc(8'h08, 1'b0);
        chk("pre-reset idx", int'(gnt_idx), 3);
        #2;
        rst_n = 1'b0;
        req   = 8'h50;
        #1;
        chk("async rst valid",  int'(gnt_valid),  0);
        chk("async rst idx",    int'(gnt_idx),    0);
        chk("async rst onehot", int'(gnt_onehot), 0);
        chk("async rst timeout", int'(timeout),   0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8'h50, 1'b0);
        chk("post-reset idx", int'(gnt_idx), 4);
        cyc(8'h50, 1'b1);
        cyc(8'h50, 1'b0);
        chk("post-reset next", int'(gnt_idx), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
